// File: rtl/cu_mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cu_mem_pkg                                                    |
// | Description : Shared size codes, fault codes and sequencer states for the   |
// |               control-unit RAM access path.                                 |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
package cu_mem_pkg;

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_WORD     = 2'b10;
    localparam logic [1:0] SZ_RSVD     = 2'b11;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ALIGN   = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;
    localparam logic [1:0] FLT_SIZE    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RELEASE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mfc_timeout_ctr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mfc_timeout_ctr                                               |
// | Description : Counts cycles spent waiting for ramMFC; flags the edge on     |
// |               which the count reaches TIMEOUT.                              |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module mfc_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted while the count is about to step onto TIMEOUT, so the owner
    // reacts on exactly that edge.
    assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : mem_access_seq                                                |
// | Description : Load/store sequencer running the ramMFA/ramMFC four-phase     |
// |               handshake with size/alignment checks and MFC timeout.         |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module mem_access_seq
    import cu_mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              signExt,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ramMFC,
    input  logic [DATA_W-1:0] ramRdata,
    output logic              ramMFA,
    output logic              ramRW,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [1:0]        ramDataSize,
    output logic [DATA_W-1:0] ramWdata,
    output logic [DATA_W-1:0] mdrData,
    output logic              mdrEnable,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [1:0]        faultCode
);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_signExt;
    logic              w_accept;
    logic              w_expired;
    logic              w_ctrEnable;
    logic [1:0]        w_reqFault;
    logic [DATA_W-1:0] w_loadExt;
    logic              w_nxtMfa;
    logic              w_nxtBusy;
    logic              w_nxtDone;
    logic              w_nxtFault;
    logic              w_nxtMdrEn;
    logic [1:0]        w_nxtFaultCode;
    logic [DATA_W-1:0] w_nxtMdrData;

    assign w_ctrEnable = (r_state == WAIT);

    mfc_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeoutCtr (
        .clk       (Clk),
        .rst       (reset),
        .i_clear   (!w_ctrEnable),
        .i_enable  (w_ctrEnable),
        .o_expired (w_expired)
    );

    always_comb begin
        w_reqFault = FLT_NONE;
        case (size)
            SZ_HALF: if (addr[0])            w_reqFault = FLT_ALIGN;
            SZ_WORD: if (addr[1:0] != 2'b00) w_reqFault = FLT_ALIGN;
            SZ_RSVD:                         w_reqFault = FLT_SIZE;
            default: ;
        endcase
    end

    // Extension uses the size/sign captured at start, not the live inputs.
    always_comb begin
        w_loadExt = ramRdata;
        case (ramDataSize)
            SZ_BYTE: w_loadExt = {{(DATA_W-8){r_signExt & ramRdata[7]}}, ramRdata[7:0]};
            SZ_HALF: w_loadExt = {{(DATA_W-16){r_signExt & ramRdata[15]}}, ramRdata[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_nextState    = r_state;
        w_accept       = 1'b0;
        w_nxtMfa       = ramMFA;
        w_nxtBusy      = busy;
        w_nxtDone      = 1'b0;
        w_nxtFault     = 1'b0;
        w_nxtMdrEn     = 1'b0;
        w_nxtFaultCode = faultCode;
        w_nxtMdrData   = mdrData;
        case (r_state)
            IDLE: begin
                w_nxtBusy = 1'b0;
                if (start) begin
                    w_nxtFaultCode = w_reqFault;
                    if (w_reqFault != FLT_NONE) begin
                        w_nxtFault = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_nxtMfa    = 1'b1;
                        w_nxtBusy   = 1'b1;
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ramMFC) begin
                    w_nxtMfa    = 1'b0;
                    w_nxtDone   = 1'b1;
                    w_nextState = RELEASE;
                    if (ramRW) begin
                        w_nxtMdrEn   = 1'b1;
                        w_nxtMdrData = w_loadExt;
                    end
                end else if (w_expired) begin
                    w_nxtMfa       = 1'b0;
                    w_nxtFault     = 1'b1;
                    w_nxtFaultCode = FLT_TIMEOUT;
                    w_nextState    = RELEASE;
                end
            end
            RELEASE: begin
                // No new MFA until the RAM has withdrawn MFC.
                if (!ramMFC) begin
                    w_nxtBusy   = 1'b0;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nxtMfa    = 1'b0;
                w_nxtBusy   = 1'b0;
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_signExt   <= 1'b0;
            ramMFA      <= 1'b0;
            ramRW       <= 1'b0;
            ramAddress  <= '0;
            ramDataSize <= 2'b00;
            ramWdata    <= '0;
            mdrData     <= '0;
            mdrEnable   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            faultCode   <= FLT_NONE;
        end else begin
            r_state   <= w_nextState;
            ramMFA    <= w_nxtMfa;
            busy      <= w_nxtBusy;
            done      <= w_nxtDone;
            fault     <= w_nxtFault;
            faultCode <= w_nxtFaultCode;
            mdrEnable <= w_nxtMdrEn;
            mdrData   <= w_nxtMdrData;
            if (w_accept) begin
                ramRW       <= rw;
                ramAddress  <= addr;
                ramDataSize <= size;
                ramWdata    <= wdata;
                r_signExt   <= signExt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_mem_access_seq                                             |
// | Description : Scoreboard bench for mem_access_seq with directed accesses.   |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tb_mem_access_seq;
    import cu_mem_pkg::*;

    localparam int TMO = 16;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        signExt = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ramMFC = 1'b0;
    logic [31:0] ramRdata = '0;
    logic        ramMFA, ramRW, mdrEnable, busy, done, fault;
    logic [8:0]  ramAddress;
    logic [1:0]  ramDataSize, faultCode;
    logic [31:0] ramWdata, mdrData;

    typedef struct {
        logic        done;
        logic        fault;
        logic [1:0]  code;
        logic        mdrEn;
        logic [31:0] data;
    } ev_t;

    ev_t expQ[$];
    ev_t monEv;
    int  total = 0;
    int  bad = 0;
    int  cnt;

    mem_access_seq #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .reset(reset), .start(start), .rw(rw), .size(size),
        .signExt(signExt), .addr(addr), .wdata(wdata), .ramMFC(ramMFC),
        .ramRdata(ramRdata), .ramMFA(ramMFA), .ramRW(ramRW),
        .ramAddress(ramAddress), .ramDataSize(ramDataSize), .ramWdata(ramWdata),
        .mdrData(mdrData), .mdrEnable(mdrEnable), .busy(busy), .done(done),
        .fault(fault), .faultCode(faultCode)
    );

    always #1 Clk = ~Clk;

    initial begin
        #40000;
        $display("FAIL watchdog: simulation did not finish, required finish before 40000");
        $fatal(1);
    end

    // Monitor: every done/fault/mdrEnable pulse must match the next queued event.
    always @(negedge Clk) begin
        if (done || fault || mdrEnable) begin
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got done=%0b fault=%0b mdrEnable=%0b code=%0d, required no event",
                         done, fault, mdrEnable, faultCode);
            end else begin
                monEv = expQ.pop_front();
                if (done !== monEv.done || fault !== monEv.fault || faultCode !== monEv.code ||
                    mdrEnable !== monEv.mdrEn || (monEv.mdrEn && mdrData !== monEv.data)) begin
                    bad++;
                    $display("FAIL event: got done=%0b fault=%0b code=%0d mdrEn=%0b data=%h, required done=%0b fault=%0b code=%0d mdrEn=%0b data=%h",
                             done, fault, faultCode, mdrEnable, mdrData,
                             monEv.done, monEv.fault, monEv.code, monEv.mdrEn, monEv.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic pushEv(input logic d, input logic f, input logic [1:0] c,
                          input logic m, input logic [31:0] v);
        ev_t e;
        e.done = d; e.fault = f; e.code = c; e.mdrEn = m; e.data = v;
        expQ.push_back(e);
    endtask

    task automatic issue(input logic rwI, input logic [1:0] sz, input logic sx,
                         input logic [8:0] a, input logic [31:0] wd);
        rw = rwI; size = sz; signExt = sx; addr = a; wdata = wd; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // lat: edges from the MFA rise to the edge that samples MFC.
    // hold: extra cycles MFC stays high after done; poke issues starts in that window.
    task automatic doAccess(input logic rwI, input logic [1:0] sz, input logic sx,
                            input logic [8:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input logic [31:0] expData, input int lat, input int hold,
                            input logic poke);
        pushEv(1'b1, 1'b0, FLT_NONE, rwI, expData);
        issue(rwI, sz, sx, a, wd);
        chk("mfa_rise", ramMFA, 1);
        chk("busy_rise", busy, 1);
        chk("ram_fields", {ramRW, ramDataSize, ramAddress}, {rwI, sz, a});
        if (!rwI) chk("ram_wdata", ramWdata, wd);
        repeat (lat - 1) @(negedge Clk);
        chk("mfa_before_mfc", ramMFA, 1);
        ramMFC = 1'b1;
        ramRdata = rd;
        @(negedge Clk);
        chk("mfa_fall", ramMFA, 0);
        chk("addr_stable", ramAddress, a);
        for (int i = 0; i < hold; i++) begin
            start = (poke && (i == 1));
            @(negedge Clk);
            chk("busy_in_release", busy, 1);
            chk("mfa_in_release", ramMFA, 0);
        end
        start = poke;
        ramMFC = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        chk("busy_fall", busy, 0);
        chk("mfa_after_release", ramMFA, 0);
    endtask

    initial begin
        @(negedge Clk);
        chk("reset_outputs", {ramMFA, ramRW, busy, done, fault, mdrEnable, faultCode, ramDataSize}, 0);
        chk("reset_data", mdrData | ramWdata | {23'd0, ramAddress}, 0);
        @(negedge Clk);
        reset = 1'b0;

        // Word read, MFC sampled on the third edge after the MFA rise
        doAccess(1'b1, SZ_WORD, 1'b0, 9'h004, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0, 1'b0);

        // Byte/half loads with sign and zero extension, minimum latency
        doAccess(1'b1, SZ_BYTE, 1'b1, 9'h003, 32'h0, 32'h00000080, 32'hFFFFFF80, 1, 0, 1'b0);
        doAccess(1'b1, SZ_BYTE, 1'b0, 9'h003, 32'h0, 32'h00000080, 32'h00000080, 1, 0, 1'b0);
        doAccess(1'b1, SZ_HALF, 1'b1, 9'h002, 32'h0, 32'h00008001, 32'hFFFF8001, 2, 0, 1'b0);
        doAccess(1'b1, SZ_HALF, 1'b0, 9'h006, 32'h0, 32'h12348001, 32'h00008001, 1, 0, 1'b0);
        doAccess(1'b1, SZ_BYTE, 1'b1, 9'h001, 32'h0, 32'hABCDEF7F, 32'h0000007F, 1, 0, 1'b0);

        // Store: no MDR strobe, mdrData keeps the last load
        doAccess(1'b0, SZ_BYTE, 1'b0, 9'h005, 32'h00000055, 32'hFFFFFFFF, 32'h0, 2, 0, 1'b0);
        chk("mdr_hold", mdrData, 32'h0000007F);

        // Request faults
        pushEv(1'b0, 1'b1, FLT_ALIGN, 1'b0, 32'h0);
        issue(1'b0, SZ_HALF, 1'b0, 9'h003, 32'h1234);
        chk("misalign_half_code", faultCode, FLT_ALIGN);
        chk("misalign_no_mfa", {ramMFA, busy}, 0);
        pushEv(1'b0, 1'b1, FLT_ALIGN, 1'b0, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 9'h006, 32'h0);
        chk("misalign_word_code", faultCode, FLT_ALIGN);
        pushEv(1'b0, 1'b1, FLT_SIZE, 1'b0, 32'h0);
        issue(1'b1, SZ_RSVD, 1'b0, 9'h000, 32'h0);
        chk("bad_size_code", faultCode, FLT_SIZE);
        chk("bad_size_no_mfa", ramMFA, 0);
        @(negedge Clk);
        chk("fault_code_held", faultCode, FLT_SIZE);

        // Timeout, then a late MFC pulse that must not produce done
        pushEv(1'b0, 1'b1, FLT_TIMEOUT, 1'b0, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 9'h010, 32'h0);
        cnt = 0;
        while (ramMFA === 1'b1 && cnt < 64) begin
            cnt++;
            @(negedge Clk);
        end
        chk("timeout_mfa_cycles", cnt, TMO);
        chk("timeout_code", faultCode, FLT_TIMEOUT);
        ramMFC = 1'b1;
        @(negedge Clk);
        chk("late_mfc_busy", busy, 1);
        ramMFC = 1'b0;
        @(negedge Clk);
        chk("late_mfc_idle", busy, 0);

        // MFC held 5 cycles after done; starts in that window are ignored
        doAccess(1'b1, SZ_WORD, 1'b0, 9'h008, 32'h0, 32'h01020304, 32'h01020304, 1, 5, 1'b1);
        doAccess(1'b0, SZ_WORD, 1'b0, 9'h00C, 32'hCAFEF00D, 32'h0, 32'h0, 2, 0, 1'b0);

        // Reset during WAIT
        issue(1'b1, SZ_WORD, 1'b0, 9'h020, 32'h0);
        chk("rst_mid_mfa_up", ramMFA, 1);
        reset = 1'b1;
        @(negedge Clk);
        chk("rst_mid_outputs", {ramMFA, busy, done, fault}, 0);
        reset = 1'b0;
        ramMFC = 1'b1;
        @(negedge Clk);
        chk("rst_mid_stays_idle", {ramMFA, busy}, 0);
        ramMFC = 1'b0;
        doAccess(1'b1, SZ_HALF, 1'b1, 9'h022, 32'h0, 32'h00007FFF, 32'h00007FFF, 1, 0, 1'b0);

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
